edge_detector_bank: RTL and testbench



---
 rtl/edge_detector_bank.sv | 87 ++++++++
 tb/tb_edge_detector_bank.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detector_bank.sv
// Multi-channel edge detector: per channel a synchroniser, a persistence filter,
// a mode-selected one-cycle event strobe, a sticky pending flag and a saturating counter.
module edge_detector_bank #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter     MODE        = "RISE",
    parameter int CNT_WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           stb_in,
    input  logic [WIDTH-1:0]           clear,
    output logic [WIDTH-1:0]           level_out,
    output logic [WIDTH-1:0]           stb_out,
    output logic [WIDTH-1:0]           pending,
    output logic [WIDTH*CNT_WIDTH-1:0] edge_count
);

    localparam int FW = $clog2(FILTER_LEN) + 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    // Anything other than "RISE" or "FALL" reports both directions.
    localparam bit USE_RISE = (MODE != "FALL");
    localparam bit USE_FALL = (MODE != "RISE");

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [FW-1:0]          filt_reg;
            logic                   level_reg;
            logic                   stb_reg;
            logic                   pend_reg;
            logic [CNT_WIDTH-1:0]   cnt_reg;
            logic                   sync_bit;
            logic                   accept;
            logic                   event_hit;

            assign sync_bit  = sync_reg[SYNC_STAGES-1];
            // A change is accepted once it has differed for FILTER_LEN consecutive cycles.
            assign accept    = (sync_bit != level_reg) && (filt_reg == FILT_LAST);
            assign event_hit = accept && (level_reg ? USE_FALL : USE_RISE);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_reg  <= '0;
                    filt_reg  <= '0;
                    level_reg <= 1'b0;
                    stb_reg   <= 1'b0;
                    pend_reg  <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync_reg[0] <= stb_in[gi];
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        sync_reg[s] <= sync_reg[s-1];
                    end

                    if (sync_bit == level_reg) begin
                        filt_reg <= '0;
                    end else if (accept) begin
                        filt_reg  <= '0;
                        level_reg <= ~level_reg;
                    end else begin
                        filt_reg <= filt_reg + 1'b1;
                    end

                    stb_reg  <= event_hit;
                    // A same-cycle event beats clear for both flag and counter.
                    pend_reg <= event_hit | (pend_reg & ~clear[gi]);

                    if (clear[gi]) begin
                        cnt_reg <= CNT_WIDTH'(event_hit);
                    end else if (event_hit && (cnt_reg != CNT_MAX)) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign level_out[gi] = level_reg;
            assign stb_out[gi]   = stb_reg;
            assign pending[gi]   = pend_reg;
            assign edge_count[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg;
        end
    endgenerate

endmodule

// File: tb/tb_edge_detector_bank.sv
// Directed bench for edge_detector_bank: several parameterisations side by side,
// table-driven vectors on the fast instance plus hand-written multi-cycle sequences.
module tb_edge_detector_bank;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // defaults (RISE)
    logic [3:0]  stb_def = '0, clr_def = '0, lvl_def, so_def, pend_def;
    logic [31:0] cnt_def;
    // FALL and BOTH share one stimulus
    logic [3:0]  stb_mode = '0, clr_mode = '0;
    logic [3:0]  lvl_fall, so_fall, pend_fall, lvl_both, so_both, pend_both;
    logic [31:0] cnt_fall, cnt_both;
    // CNT_WIDTH = 2
    logic [3:0]  stb_sat = '0, clr_sat = '0, lvl_sat, so_sat, pend_sat;
    logic [7:0]  cnt_sat;
    // SYNC_STAGES = 1, FILTER_LEN = 1, WIDTH = 8
    logic [7:0]  stb_fast = '0, clr_fast = '0, lvl_fast, so_fast, pend_fast;
    logic [63:0] cnt_fast;

    edge_detector_bank u_def (
        .clk(clk), .rst(rst), .stb_in(stb_def), .clear(clr_def),
        .level_out(lvl_def), .stb_out(so_def), .pending(pend_def), .edge_count(cnt_def));

    edge_detector_bank #(.MODE("FALL")) u_fall (
        .clk(clk), .rst(rst), .stb_in(stb_mode), .clear(clr_mode),
        .level_out(lvl_fall), .stb_out(so_fall), .pending(pend_fall), .edge_count(cnt_fall));

    edge_detector_bank #(.MODE("BOTH")) u_both (
        .clk(clk), .rst(rst), .stb_in(stb_mode), .clear(clr_mode),
        .level_out(lvl_both), .stb_out(so_both), .pending(pend_both), .edge_count(cnt_both));

    edge_detector_bank #(.CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst(rst), .stb_in(stb_sat), .clear(clr_sat),
        .level_out(lvl_sat), .stb_out(so_sat), .pending(pend_sat), .edge_count(cnt_sat));

    edge_detector_bank #(.WIDTH(8), .SYNC_STAGES(1), .FILTER_LEN(1)) u_fast (
        .clk(clk), .rst(rst), .stb_in(stb_fast), .clear(clr_fast),
        .level_out(lvl_fast), .stb_out(so_fast), .pending(pend_fast), .edge_count(cnt_fast));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end else begin
            $display("check %0d %s value %0h", checks, name, act);
        end
    endtask

    // Pulse counters sampled mid-cycle so each one-cycle strobe is seen once.
    int pc_def [4] = '{0, 0, 0, 0};
    int pc_fall = 0, pc_both = 0, pc_sat = 0;
    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < 4; c++) pc_def[c] <= pc_def[c] + int'(so_def[c]);
            pc_fall <= pc_fall + int'(so_fall[2]);
            pc_both <= pc_both + int'(so_both[2]);
            pc_sat  <= pc_sat + int'(so_sat[3]);
        end
    end

    typedef struct packed {
        logic [7:0] din;
        logic [7:0] lvl;
        logic [7:0] stb;
    } vec_t;
    vec_t tbl [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, npulse, base, expc;
        logic [7:0] h1, h2, h3, exp_stb, v, mpend;
        logic [7:0] mcnt [8];
        logic [63:0] mcnt_flat;

        // inputs held 2 cycles each from a zero history
        tbl[0] = '{8'h0F, 8'h0F, 8'h0F};
        tbl[1] = '{8'h3C, 8'h3C, 8'h30};
        tbl[2] = '{8'hFF, 8'hFF, 8'hC3};
        tbl[3] = '{8'h00, 8'h00, 8'h00};
        tbl[4] = '{8'hA5, 8'hA5, 8'hA5};
        tbl[5] = '{8'h5A, 8'h5A, 8'h5A};
        tbl[6] = '{8'hFF, 8'hFF, 8'hA5};
        tbl[7] = '{8'h81, 8'h81, 8'h00};

        // reset state
        repeat (3) @(negedge clk);
        check("reset_flags", {60'd0, lvl_def} | {so_def, pend_def}, 64'd0);
        check("reset_count", cnt_def, 64'd0);
        rst = 1'b0;

        // single rising edge on ch0: pulse at edge k+5
        @(negedge clk);
        stb_def[0] = 1'b1;
        idx = -1; npulse = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (so_def[0]) begin
                npulse++;
                if (idx < 0) idx = i;
            end
        end
        check("a_pulse_edge", 64'(idx), 64'd5);
        check("a_pulse_count", 64'(npulse), 64'd1);
        check("a_level", lvl_def, 64'h1);
        check("a_pending", pend_def, 64'h1);
        check("a_edge_count", cnt_def, 64'h1);

        // 3-cycle glitch rejected, 4-cycle pulse accepted
        @(negedge clk); stb_def[1] = 1'b1;
        repeat (3) @(negedge clk); stb_def[1] = 1'b0;
        repeat (12) @(negedge clk); #1;
        check("b_short_pulses", 64'(pc_def[1]), 64'd0);
        check("b_short_level_pend", {lvl_def[1], pend_def[1]}, 64'd0);
        @(negedge clk); stb_def[1] = 1'b1;
        repeat (4) @(negedge clk); stb_def[1] = 1'b0;
        repeat (12) @(negedge clk); #1;
        check("b_long_pulses", 64'(pc_def[1]), 64'd1);
        check("b_long_pending", pend_def, 64'h3);
        check("b_long_count_ch1", cnt_def[15:8], 64'd1);
        check("b_long_level_back", lvl_def[1], 64'd0);

        // FALL vs BOTH on ch2
        @(negedge clk); stb_mode[2] = 1'b1;
        repeat (12) @(negedge clk); #1;
        check("c_fall_on_rise", 64'(pc_fall), 64'd0);
        check("c_fall_level", lvl_fall[2], 64'd1);
        check("c_both_on_rise", 64'(pc_both), 64'd1);
        base = pc_both;
        @(negedge clk); stb_mode[2] = 1'b0;
        repeat (12) @(negedge clk); #1;
        check("c_fall_on_fall", 64'(pc_fall), 64'd1);
        @(negedge clk); stb_mode[2] = 1'b1;
        repeat (12) @(negedge clk); #1;
        check("c_fall_total", 64'(pc_fall), 64'd1);
        check("c_fall_count", cnt_fall[23:16], 64'd1);
        check("c_both_delta", 64'(pc_both - base), 64'd2);

        // 2-bit counter saturation on ch3
        for (int e = 0; e < 6; e++) begin
            @(negedge clk); stb_sat[3] = 1'b1;
            repeat (8) @(negedge clk); #1;
            expc = (e + 1 > 3) ? 3 : e + 1;
            check($sformatf("d_sat_count_%0d", e), cnt_sat[7:6], 64'(expc));
            @(negedge clk); stb_sat[3] = 1'b0;
            repeat (8) @(negedge clk);
        end
        check("d_sat_pulses", 64'(pc_sat), 64'd6);
        @(negedge clk); clr_sat[3] = 1'b1;
        @(negedge clk); clr_sat[3] = 1'b0; #1;
        check("d_clear", {pend_sat[3], cnt_sat[7:6]}, 64'd0);
        // clear lands on the event edge k+5
        @(negedge clk); stb_sat[3] = 1'b1;
        repeat (5) @(negedge clk); clr_sat[3] = 1'b1;
        @(negedge clk); clr_sat[3] = 1'b0; #1;
        check("d_coincident", {so_sat[3], pend_sat[3], cnt_sat[7:6]}, 64'b1_1_01);

        // asynchronous reset mid-filter on u_def ch3
        @(negedge clk); stb_def[3] = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1; #1;
        check("e_async_reset", {lvl_def, so_def, pend_def, cnt_def}, 64'd0);
        check("e_async_reset_sat", {pend_sat, cnt_sat}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idx = -1; npulse = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (so_def[3]) begin
                npulse++;
                if (idx < 0) idx = i;
            end
        end
        check("e_release_edge", 64'(idx), 64'd5);
        check("e_release_count", 64'(npulse), 64'd1);
        check("e_release_level", lvl_def[3], 64'd1);

        // fast instance, random stimulus vs scoreboard
        h1 = '0; h2 = '0; h3 = '0; mpend = '0;
        for (int c = 0; c < 8; c++) mcnt[c] = '0;
        for (int t = 0; t < 150; t++) begin
            @(negedge clk);
            exp_stb = h2 & ~h3;
            for (int c = 0; c < 8; c++) begin
                if (exp_stb[c]) begin
                    mpend[c] = 1'b1;
                    if (mcnt[c] != 8'hFF) mcnt[c] = mcnt[c] + 8'd1;
                end
                mcnt_flat[c*8 +: 8] = mcnt[c];
            end
            check($sformatf("f_rand_%0d", t), {lvl_fast, so_fast, pend_fast}, {40'd0, h2, exp_stb, mpend});
            check($sformatf("f_rand_cnt_%0d", t), cnt_fast, mcnt_flat);
            v = 8'($urandom);
            stb_fast = v;
            h3 = h2; h2 = h1; h1 = v;
        end

        // fast instance, table vectors
        @(negedge clk); stb_fast = '0;
        repeat (3) @(negedge clk);
        for (int r = 0; r < 8; r++) begin
            stb_fast = tbl[r].din;
            repeat (2) @(negedge clk);
            check($sformatf("g_tbl_level_%0d", r), lvl_fast, tbl[r].lvl);
            check($sformatf("g_tbl_stb_%0d", r), so_fast, tbl[r].stb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
